pipe_ctrl: RTL
==============

# pipe_ctrl

Pipeline sequencing controller for the five-stage core. It sits beside the decode unit and generates per-stage stall and flush controls plus the PC redirect. It covers four cases: load-use hazards that forwarding cannot cover, taken jumps/branches from the execute stage, multi-cycle execute operations such as a divider, and debug halt requests. It also keeps a saturating count of front-end stall cycles for performance monitoring.

## Interface
- `CNT_W`, default 32: width of the stall-cycle counter.
- `clk`  in  1  core clock.
- `rst`  in  1  asynchronous, active-high reset.
- `id_rs1_re_i`  in  1  decode reads rs1.
- `id_rs1_addr_i`  in  `REG_ADDR_BUS`  decode rs1 address.
- `id_rs2_re_i`  in  1  decode reads rs2.
- `id_rs2_addr_i`  in  `REG_ADDR_BUS`  decode rs2 address.
- `ex_load_i`  in  1  the instruction in execute is a load.
- `ex_rd_addr_i`  in  `REG_ADDR_BUS`  rd address of the instruction in execute.
- `ex_jump_i`  in  1  execute resolves a taken jump/branch this cycle.
- `ex_jump_addr_i`  in  32  target of that jump.
- `mc_req_i`  in  1  level; a multi-cycle op occupies execute.
- `mc_done_i`  in  1  one-cycle pulse; the multi-cycle result is valid this cycle.
- `halt_req_i`  in  1  debug halt request, level.
- `stall_o`  out  4  hold enables: [0] pc, [1] if_id, [2] id_ex, [3] ex_ls.
- `flush_o`  out  3  bubble inserts: [0] if_id, [1] id_ex, [2] ex_ls.
- `pc_jump_o`  out  1  load `pc_jump_addr_o` into the PC.
- `pc_jump_addr_o`  out  32  redirect target.
- `halted_o`  out  1  core is halted (registered).
- `stall_cnt_o`  out  `CNT_W`  saturating count of cycles with `stall_o[0]=1`.

## Operation
- States: RUN, MC_WAIT, HALTED. The state is registered. `stall_o`, `flush_o` and `pc_jump_*` are combinational from the state and the inputs.
- A load-use hazard (lu) is defined as:
  - `ex_load_i`, and
  - `ex_rd_addr_i != 0`, and
  - (`id_rs1_re_i` & `id_rs1_addr_i == ex_rd_addr_i`) or the same condition on rs2.
- RUN evaluates events in priority order; the first match applies:
  1. `ex_jump_i`: `pc_jump_o=1`, `pc_jump_addr_o=ex_jump_addr_i`, `flush_o=3'b011`, no stall. Stay in RUN.
  2. `mc_req_i & !mc_done_i`: `stall_o=4'b1111`, `flush_o=3'b100`. Next state MC_WAIT.
  3. lu: `stall_o=4'b0011`, `flush_o=3'b010` (a one-cycle bubble). Stay in RUN. After the bubble, LSU forwarding resolves the hazard.
  4. `halt_req_i`: next state HALTED. This cycle has no stall; the instruction in flight advances.
  5. No event: all outputs 0.
- `mc_req_i & mc_done_i` in the same RUN cycle is a single-cycle result: no stall, stay in RUN.
- MC_WAIT:
  - While `!mc_done_i`: `stall_o=4'b1111`, `flush_o=3'b100`.
  - On `mc_done_i`: `stall_o=0`, `flush_o=0` (the result advances into ex_ls). Next state RUN.
  - `ex_jump_i` and `halt_req_i` are ignored in MC_WAIT. A pending halt is taken in the next RUN cycle.
- HALTED:
  - `stall_o=4'b1111`, `flush_o=3'b100`.
  - `halt_req_i` low: next state RUN.
- `pc_jump_addr_o` is 0 whenever `pc_jump_o=0`.
- `stall_cnt_o`: +1 every cycle with `stall_o[0]=1` while `rst` is low; saturates at all-ones and never wraps.
- The core's x0 register is never a hazard source.

## Timing
- Reset (asynchronous, takes effect immediately, including mid-MC_WAIT or in HALTED):
  - state is RUN, `halted_o=0`, `stall_cnt_o=0`.
  - While `rst` is high: `stall_o=4'b1111`, `flush_o=0`, `pc_jump_o=0`.
- Hazard, jump and multi-cycle responses take effect in the same cycle as the causing input (zero latency, combinational).
- Load-use costs exactly 1 stall cycle.
- A multi-cycle op with done at request cycle +N (N≥1) costs N stall cycles.
- `halted_o` rises one cycle after `halt_req_i` is accepted in RUN. It falls one cycle after `halt_req_i` deasserts.
- Simultaneous events: jump+lu → jump only; mc+lu → mc only; jump+mc → jump (the exu never issues both).

## Structure
- Shared package/`defines.v`: the stage index macros, `STALL_BUS`/`FLUSH_BUS` widths, and the state encodings (`CTRL_RUN=2'd0`, `CTRL_MC_WAIT=2'd1`, `CTRL_HALTED=2'd2`).
- One sub-module is natural: `sat_cnt`, a parameterised saturating counter that can be reused for other performance counters.
- The hazard compare stays inline.

## Test plan
- Load-use: `ex_load_i=1`, `ex_rd_addr_i=5`, `id_rs1_re_i=1`, `id_rs1_addr_i=5` → `stall_o=0011`, `flush_o=010` for 1 cycle, `stall_cnt_o` 0→1. The same stimulus with `ex_rd_addr_i=0` → no stall.
- Jump with concurrent hazard: `ex_jump_i=1`, `ex_jump_addr_i=32'h8000_0040`, lu active → `pc_jump_o=1`, addr `8000_0040`, `flush_o=011`, `stall_o=0`.
- Multi-cycle wait:
  - Stimulus: `mc_req_i` high at cycle 0, `mc_done_i` pulse at cycle 4.
  - Required response: `stall_o=1111` during cycles 0–3, 0 at cycle 4, state back to RUN at cycle 5, `stall_cnt_o=4`.
- Single-cycle result: `mc_req_i=1` and `mc_done_i=1` in the same cycle → no stall.
- Halt:
  - Stimulus: `halt_req_i` raised during MC_WAIT, held, then dropped.
  - Required response: HALTED entered only after `mc_done_i`, `halted_o=1` on the next cycle. After the drop, `halted_o=0` one cycle later.
- Reset mid-MC_WAIT: assert `rst` asynchronously → `stall_o=1111`, `halted_o=0`, `stall_cnt_o=0` immediately. After release with no requests → all outputs 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: bus widths,
// stage indices, FSM state encoding and the canned stall/flush patterns.
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int STALL_W    = 4;
  localparam int FLUSH_W    = 3;

  localparam int STG_PC    = 0;
  localparam int STG_IF_ID = 1;
  localparam int STG_ID_EX = 2;
  localparam int STG_EX_LS = 3;

  localparam int FL_IF_ID = 0;
  localparam int FL_ID_EX = 1;
  localparam int FL_EX_LS = 2;

  typedef enum logic [1:0] {
    CTRL_RUN     = 2'd0,
    CTRL_MC_WAIT = 2'd1,
    CTRL_HALTED  = 2'd2
  } ctrl_state_e;

  localparam logic [STALL_W-1:0] STALL_NONE  = 4'b0000;
  localparam logic [STALL_W-1:0] STALL_ALL   = 4'b1111;
  localparam logic [STALL_W-1:0] STALL_FRONT = 4'b0011;

  localparam logic [FLUSH_W-1:0] FLUSH_NONE   = 3'b000;
  localparam logic [FLUSH_W-1:0] FLUSH_JUMP   = 3'b011;
  localparam logic [FLUSH_W-1:0] FLUSH_BUBBLE = 3'b010;
  localparam logic [FLUSH_W-1:0] FLUSH_EX     = 3'b100;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Decode/execute status in, per-stage stall/flush and PC redirect out.
interface pipe_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
);
  logic                  id_rs1_re_i;
  logic [REG_ADDR_W-1:0] id_rs1_addr_i;
  logic                  id_rs2_re_i;
  logic [REG_ADDR_W-1:0] id_rs2_addr_i;
  logic                  ex_load_i;
  logic [REG_ADDR_W-1:0] ex_rd_addr_i;
  logic                  ex_jump_i;
  logic [31:0]           ex_jump_addr_i;
  logic                  mc_req_i;
  logic                  mc_done_i;
  logic                  halt_req_i;
  logic [STALL_W-1:0]    stall_o;
  logic [FLUSH_W-1:0]    flush_o;
  logic                  pc_jump_o;
  logic [31:0]           pc_jump_addr_o;
  logic                  halted_o;
  logic [CNT_W-1:0]      stall_cnt_o;

  // Controller side
  modport master (
    input  id_rs1_re_i, id_rs1_addr_i, id_rs2_re_i, id_rs2_addr_i,
           ex_load_i, ex_rd_addr_i, ex_jump_i, ex_jump_addr_i,
           mc_req_i, mc_done_i, halt_req_i,
    output stall_o, flush_o, pc_jump_o, pc_jump_addr_o, halted_o, stall_cnt_o
  );

  // Core side
  modport slave (
    output id_rs1_re_i, id_rs1_addr_i, id_rs2_re_i, id_rs2_addr_i,
           ex_load_i, ex_rd_addr_i, ex_jump_i, ex_jump_addr_i,
           mc_req_i, mc_done_i, halt_req_i,
    input  stall_o, flush_o, pc_jump_o, pc_jump_addr_o, halted_o, stall_cnt_o
  );

endinterface

// File: rtl/pipe_ctrl_sat_cnt.sv
// Saturating up-counter for performance monitoring; sticks at all-ones.
module pipe_ctrl_sat_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (en && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, jump flushes,
// multi-cycle execute waits and debug halt, plus a stall-cycle counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.master bus
);

  ctrl_state_e        state_q;
  logic               halted_q;
  logic               lu;
  logic               mc_start;
  logic [STALL_W-1:0] stall;
  logic [FLUSH_W-1:0] flush;
  logic               pc_jump;
  logic [31:0]        pc_jump_addr;
  logic [CNT_W-1:0]   stall_cnt;

  // x0 never carries a hazard since it is hard-wired to zero.
  assign lu = bus.ex_load_i && (bus.ex_rd_addr_i != '0) &&
              ((bus.id_rs1_re_i && (bus.id_rs1_addr_i == bus.ex_rd_addr_i)) ||
               (bus.id_rs2_re_i && (bus.id_rs2_addr_i == bus.ex_rd_addr_i)));

  // A request with done in the same cycle is a single-cycle result.
  assign mc_start = bus.mc_req_i && !bus.mc_done_i;

  always_comb begin
    stall        = STALL_NONE;
    flush        = FLUSH_NONE;
    pc_jump      = 1'b0;
    pc_jump_addr = '0;
    if (rst) begin
      stall = STALL_ALL;
    end else begin
      unique case (state_q)
        CTRL_RUN: begin
          if (bus.ex_jump_i) begin
            pc_jump      = 1'b1;
            pc_jump_addr = bus.ex_jump_addr_i;
            flush        = FLUSH_JUMP;
          end else if (mc_start) begin
            stall = STALL_ALL;
            flush = FLUSH_EX;
          end else if (lu) begin
            stall = STALL_FRONT;
            flush = FLUSH_BUBBLE;
          end
        end
        CTRL_MC_WAIT: begin
          if (!bus.mc_done_i) begin
            stall = STALL_ALL;
            flush = FLUSH_EX;
          end
        end
        CTRL_HALTED: begin
          stall = STALL_ALL;
          flush = FLUSH_EX;
        end
        default: begin
          stall = STALL_ALL;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= CTRL_RUN;
      halted_q <= 1'b0;
    end else begin
      unique case (state_q)
        CTRL_RUN: begin
          if (!bus.ex_jump_i && mc_start) begin
            state_q <= CTRL_MC_WAIT;
          end else if (!bus.ex_jump_i && !lu && bus.halt_req_i) begin
            state_q  <= CTRL_HALTED;
            halted_q <= 1'b1;
          end
        end
        CTRL_MC_WAIT: begin
          if (bus.mc_done_i) begin
            state_q <= CTRL_RUN;
          end
        end
        CTRL_HALTED: begin
          if (!bus.halt_req_i) begin
            state_q  <= CTRL_RUN;
            halted_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= CTRL_RUN;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  pipe_ctrl_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .en  (stall[STG_PC]),
    .cnt (stall_cnt)
  );

  assign bus.stall_o        = stall;
  assign bus.flush_o        = flush;
  assign bus.pc_jump_o      = pc_jump;
  assign bus.pc_jump_addr_o = pc_jump_addr;
  assign bus.halted_o       = halted_q;
  assign bus.stall_cnt_o    = stall_cnt;

endmodule
